// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - active-low matrix keypad scanner with frame debounce
// and a one-entry key code buffer.
module keypad_scanner #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int DEBOUNCE = 3,
  localparam int KW      = $clog2(ROWS*COLS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            scan_clk,
  input  logic [COLS-1:0] col_in,
  output logic [ROWS-1:0] row_out,
  output logic [KW-1:0]   key_code,
  output logic            key_valid,
  input  logic            key_ready,
  output logic            overrun
);

  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CLW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CNTW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {RES_NONE = 2'd0, RES_SINGLE = 2'd1, RES_MULTI = 2'd2} res_t;

  logic            sc_s1, sc_s2, sc_s3;
  logic [2:0]      fill;
  logic [COLS-1:0] col_s1, col_s2;
  logic            tick;

  logic [RW-1:0]   row_idx;
  logic [1:0]      acc_cnt;
  logic [KW-1:0]   acc_code;
  res_t            cand_kind, stable_kind;
  logic [KW-1:0]   cand_code;
  logic [CNTW-1:0] cnt;
  logic            press_evt;
  logic [KW-1:0]   press_code;

  logic [COLS-1:0] hits;
  logic [1:0]      row_cnt;
  logic [CLW-1:0]  row_col;
  logic [2:0]      sum;
  logic [1:0]      tot_cnt;
  logic [KW-1:0]   hit_code;
  res_t            frame_kind;
  logic [KW-1:0]   frame_code;
  logic            last_row;
  logic            same;
  logic [CNTW-1:0] new_cnt;
  logic [RW-1:0]   next_idx;
  logic            hs;

  // fill holds off the edge detector until all three scan flops carry real samples
  assign tick     = sc_s2 & ~sc_s3 & fill[2];
  assign hits     = ~col_s2;
  assign last_row = (row_idx == RW'(ROWS - 1));
  assign next_idx = last_row ? '0 : row_idx + RW'(1);
  assign hs       = key_valid & key_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sc_s1  <= 1'b0;
      sc_s2  <= 1'b0;
      sc_s3  <= 1'b0;
      fill   <= '0;
      col_s1 <= '0;
      col_s2 <= '0;
    end else begin
      sc_s1  <= scan_clk;
      sc_s2  <= sc_s1;
      sc_s3  <= sc_s2;
      fill   <= {fill[1:0], 1'b1};
      col_s1 <= col_in;
      col_s2 <= col_s1;
    end
  end

  always_comb begin
    row_cnt = 2'd0;
    row_col = '0;
    for (int c = 0; c < COLS; c++) begin
      if (hits[c]) begin
        if (row_cnt == 2'd0) row_col = CLW'(c);
        if (row_cnt != 2'd2) row_cnt = row_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    sum      = {1'b0, acc_cnt} + {1'b0, row_cnt};
    tot_cnt  = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    hit_code = (acc_cnt != 2'd0) ? acc_code : KW'(int'(row_idx) * COLS + int'(row_col));
    case (tot_cnt)
      2'd0:    frame_kind = RES_NONE;
      2'd1:    frame_kind = RES_SINGLE;
      default: frame_kind = RES_MULTI;
    endcase
    // Code is zeroed for NONE/MULTI so a plain compare decides frame equality
    frame_code = (frame_kind == RES_SINGLE) ? hit_code : '0;
    same       = (frame_kind == cand_kind) && (frame_code == cand_code);
    if (!same)                          new_cnt = CNTW'(1);
    else if (cnt == CNTW'(DEBOUNCE))    new_cnt = cnt;
    else                                new_cnt = cnt + CNTW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_idx     <= '0;
      row_out     <= ~(ROWS'(1));
      acc_cnt     <= 2'd0;
      acc_code    <= '0;
      cand_kind   <= RES_NONE;
      cand_code   <= '0;
      cnt         <= '0;
      stable_kind <= RES_NONE;
      press_evt   <= 1'b0;
      press_code  <= '0;
    end else begin
      press_evt <= 1'b0;
      if (tick) begin
        row_idx <= next_idx;
        row_out <= ~(ROWS'(1) << next_idx);
        if (last_row) begin
          acc_cnt   <= 2'd0;
          acc_code  <= '0;
          cand_kind <= frame_kind;
          cand_code <= frame_code;
          cnt       <= new_cnt;
          if (new_cnt == CNTW'(DEBOUNCE)) begin
            stable_kind <= frame_kind;
            press_evt   <= (stable_kind == RES_NONE) && (frame_kind == RES_SINGLE);
            press_code  <= frame_code;
          end
        end else begin
          acc_cnt  <= tot_cnt;
          acc_code <= hit_code;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (press_evt) begin
        if (!key_valid || hs) begin
          key_code  <= press_code;
          key_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (hs) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner with a
// frame-level reference model.
module tb_keypad_scanner;

  localparam int D = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        scan_clk = 1'b0;
  logic        key_ready = 1'b0;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        overrun;
  logic [15:0] keys = '0;

  int checks = 0;
  int errors = 0;
  int got_q[$];
  int exp_q[$];
  int hist[$];
  int stable_m = -1;
  int ovr_cnt = 0;

  keypad_scanner #(.ROWS(4), .COLS(4), .DEBOUNCE(D)) dut (
    .clk(clk), .rst(rst), .scan_clk(scan_clk), .col_in(col_in), .row_out(row_out),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always begin
    repeat (5) @(posedge clk);
    #2 scan_clk = ~scan_clk;
  end

  // Ideal switch matrix: a held key pulls its column low while its row is driven
  always_comb begin
    col_in = 4'hF;
    for (int k = 0; k < 16; k++)
      if (keys[k] && row_out[k / 4] == 1'b0) col_in[k % 4] = 1'b0;
  end

  always @(negedge clk) begin
    if (rst) begin
      if (key_valid && key_ready) got_q.push_back(int'(key_code));
      if (overrun) ovr_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int frame_res(input logic [15:0] m);
    int n;
    n = $countones(m);
    if (n == 0) return -1;
    if (n > 1) return -2;
    for (int k = 0; k < 16; k++) if (m[k]) return k;
    return -1;
  endfunction

  task automatic model_reset();
    hist.delete();
    stable_m = -1;
  endtask

  // Stable result follows the frame result once the last D frames agree
  task automatic model_frame(input logic [15:0] m);
    int r;
    bit agree;
    r = frame_res(m);
    hist.push_back(r);
    if (hist.size() >= D) begin
      agree = 1'b1;
      for (int i = hist.size() - D; i < hist.size(); i++) if (hist[i] != r) agree = 1'b0;
      if (agree) begin
        if (stable_m == -1 && r >= 0) exp_q.push_back(r);
        stable_m = r;
      end
    end
  endtask

  task automatic wait_frame();
    logic [3:0] prev;
    bit done;
    done = 1'b0;
    prev = row_out;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (row_out == 4'b1110 && prev != 4'b1110) done = 1'b1;
      prev = row_out;
    end
    if (!done) check_eq("frame_timeout", 0, 1);
  endtask

  task automatic wait_row_change();
    logic [3:0] prev;
    bit done;
    done = 1'b0;
    prev = row_out;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (row_out != prev) done = 1'b1;
    end
    if (!done) check_eq("row_timeout", 0, 1);
  endtask

  task automatic frames(input logic [15:0] m, input int n);
    keys = m;
    for (int i = 0; i < n; i++) begin
      wait_frame();
      model_frame(m);
    end
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 key_ready = v;
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  function automatic logic [15:0] kmask(input int k);
    logic [15:0] one;
    one = 16'd1;
    return one << k;
  endfunction

  initial begin
    int base;
    int ovr_base;
    logic [3:0] seq [4];
    seq[0] = 4'b1101; seq[1] = 4'b1011; seq[2] = 4'b0111; seq[3] = 4'b1110;

    repeat (3) @(negedge clk);
    check_eq("rst_row_out", row_out, 4'b1110);
    check_eq("rst_key_valid", key_valid, 0);
    check_eq("rst_key_code", key_code, 0);
    check_eq("rst_overrun", overrun, 0);
    rst = 1'b1;
    model_reset();

    for (int i = 0; i < 4; i++) begin
      wait_row_change();
      check_eq($sformatf("row_seq%0d", i), row_out, seq[i]);
    end
    check_eq("idle_valid", key_valid, 0);
    frames(16'h0, 3);

    // key 9 held 6 frames, consumer always ready
    set_ready(1'b1);
    base = got_q.size();
    frames(kmask(9), 2);
    settle();
    check_eq("k9_early", got_q.size() - base, 0);
    frames(kmask(9), 1);
    settle();
    check_eq("k9_count", got_q.size() - base, 1);
    if (got_q.size() > base) check_eq("k9_code", got_q[base], 9);
    frames(kmask(9), 3);
    frames(16'h0, 4);
    check_eq("k9_once", got_q.size() - base, 1);

    // bouncing key 9
    base = got_q.size();
    frames(kmask(9), 2);
    frames(16'h0, 1);
    frames(kmask(9), 2);
    settle();
    check_eq("bounce_early", got_q.size() - base, 0);
    frames(kmask(9), 1);
    settle();
    check_eq("bounce_count", got_q.size() - base, 1);
    if (got_q.size() > base) check_eq("bounce_code", got_q[base], 9);
    frames(16'h0, 4);

    // multi-key then partial release
    base = got_q.size();
    frames(kmask(0) | kmask(5), 5);
    check_eq("multi_none", got_q.size() - base, 0);
    frames(kmask(5), 5);
    check_eq("multi_to_single_none", got_q.size() - base, 0);
    frames(16'h0, 4);
    frames(kmask(5), 3);
    settle();
    check_eq("k5_count", got_q.size() - base, 1);
    if (got_q.size() > base) check_eq("k5_code", got_q[base], 5);
    frames(16'h0, 4);

    // overrun: consumer stalled across two presses
    set_ready(1'b0);
    ovr_base = ovr_cnt;
    frames(kmask(3), 4);
    frames(16'h0, 4);
    frames(kmask(7), 4);
    settle();
    check_eq("ovr_code", key_code, 3);
    check_eq("ovr_valid", key_valid, 1);
    check_eq("ovr_pulses", ovr_cnt - ovr_base, 1);
    set_ready(1'b1);
    settle();
    check_eq("ovr_drained", key_valid, 0);
    frames(16'h0, 4);

    // reset mid-frame with a pending key
    set_ready(1'b0);
    frames(kmask(6), 4);
    settle();
    check_eq("pre_rst_valid", key_valid, 1);
    check_eq("pre_rst_code", key_code, 6);
    wait_row_change();
    wait_row_change();
    @(negedge clk);
    #3 rst = 1'b0;
    #1;
    check_eq("mid_rst_row", row_out, 4'b1110);
    check_eq("mid_rst_valid", key_valid, 0);
    check_eq("mid_rst_code", key_code, 0);
    check_eq("mid_rst_ovr", overrun, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
    frames(kmask(6), 2);
    settle();
    check_eq("post_rst_early", key_valid, 0);
    frames(kmask(6), 1);
    settle();
    check_eq("post_rst_valid", key_valid, 1);
    check_eq("post_rst_code", key_code, 6);
    set_ready(1'b1);
    frames(16'h0, 4);

    // randomized press patterns against the frame model
    @(negedge clk);
    rst = 1'b0;
    keys = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
    got_q.delete();
    exp_q.delete();
    ovr_base = ovr_cnt;
    for (int s = 0; s < 25; s++) begin
      int kind, a, b, n;
      logic [15:0] m;
      kind = $urandom_range(0, 2);
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      n = $urandom_range(1, 5);
      if (kind == 0) m = '0;
      else if (kind == 1) m = kmask(a);
      else m = kmask(a) | kmask(b);
      frames(m, n);
    end
    frames(16'h0, 4);
    check_eq("rand_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq($sformatf("rand_code%0d", i), got_q[i], exp_q[i]);
    check_eq("rand_overrun", ovr_cnt - ovr_base, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
